data_mem_unit: RTL and testbench
================================

// Module: data_mem_unit
// PURPOSE
//  Data-side memory stage that consumes the CPU data bus (DA/DD/RW). It holds a DEPTH x 16 RAM,
//  an I/O window with output and status registers, and a DONE detector that flags the
//  program-complete store. After reset it clears the RAM, then serves CPU reads and writes.
//  A preload port lets the bench load data words once BUSY is low.
// PARAMETERS
//  DEPTH      128       RAM words; must be 2**AW
//  AW         7         RAM address width
//  IO_BASE    16'hFF00  I/O window base: +0 = OUTP register (R/W), +1 = status register (read-only)
//  DONE_ADDR  16'h0000  store address that sets DONE
//  DONE_VAL   16'h0004  store value that sets DONE
//  INIT_CLR   1         1 = zero-fill the RAM after reset; 0 = skip the sweep
// PORTS
//  CK     in     1   clock; all state changes on the rising edge
//  RST    in     1   asynchronous, active-low reset
//  DA     in     16  CPU data address
//  DD     inout  16  CPU data bus; driven by this block only when RW=1 and BUSY=0, else 'z
//  RW     in     1   1 = CPU read, 0 = CPU write
//  LD_EN  in     1   preload strobe
//  LD_A   in     AW  preload address
//  LD_D   in     16  preload data
//  BUSY   out    1   clear sweep in progress
//  DONE   out    1   sticky; program-complete store seen
//  ERR    out    1   sticky; access to an unmapped address
//  OUTP   out    16  output register
//  WCNT   out    16  count of accepted CPU writes; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (RST=0, async): state=INIT (state=RUN if INIT_CLR=0), sweep counter=0, BUSY=INIT_CLR,
//   DONE=0, ERR=0, OUTP=0, WCNT=0, rd_q=0, DD released. RAM contents are not reset.
//  Reset asserted mid-sweep or mid-access: the operation is abandoned and the sweep restarts from
//   address 0 after release. No partial write is guaranteed.
//  FSM INIT: each cycle mem[cnt]<=0 and cnt++. After the write of address DEPTH-1, next state is RUN
//   and BUSY falls on that same edge, so the sweep takes DEPTH cycles. CPU bus and LD are ignored.
//  FSM RUN: the terminal state until reset.
//  Decode: RAM = (DA < DEPTH); OUT = (DA == IO_BASE); STAT = (DA == IO_BASE+1); anything else
//   is unmapped.
//  Write (RW=0, RUN), on the edge:
//   - RAM: mem[DA[AW-1:0]] <= DD.
//   - OUT: OUTP <= DD.
//   - STAT: the write is dropped and is not an error.
//   - Unmapped: the write is dropped and ERR <= 1.
//   - WCNT increments only for RAM and OUT writes.
//   - DONE <= 1 when DA==DONE_ADDR and DD==DONE_VAL, regardless of region.
//  Read (RW=1, RUN): rd_q <= RAM word | OUTP | {14'b0, DONE, BUSY} | 16'h0000 with ERR<=1 (unmapped).
//   rd_q is driven on DD continuously while RW=1, giving 1-cycle latency: data for the address
//   presented in cycle n is valid from the edge ending n until the next edge.
//  Read-after-write to the same address in the next cycle returns the new data (the write
//   commits before the read samples).
//  Preload: LD_EN=1 in RUN writes mem[LD_A] <= LD_D.
//   - Preload takes priority over a same-cycle CPU RAM write to any address; that CPU write is
//     dropped and does not count in WCNT.
//   - LD_EN during INIT is ignored.
//  Bus: DD is high-Z during INIT and whenever RW=0; no cycle has both sides driving.
// STRUCTURE
//  Shared package: AW/DEPTH defaults, IO_BASE and offsets, FSM state encoding (INIT/RUN),
//   status bit positions.
//  Sub-module: dmem_ram (single-port synchronous RAM, 1 write port plus registered read);
//   decode, FSM, I/O registers and counters stay in data_mem_unit.
// TESTING
//  1 Reset, INIT_CLR=1: BUSY=1 for exactly 128 cycles after RST rises; then every address
//    reads 16'h0000.
//  2 Preload mem[0]=5, mem[1]=50; read DA=1 -> DD=50 one cycle later; read DA=0 -> 5.
//  3 Write DA=3 DD=16'h00AA, then read DA=3 next cycle -> 16'h00AA; WCNT=1.
//  4 Write DA=0 DD=4 -> DONE=1 on that edge. A following write DA=0 DD=7 leaves DONE=1.
//  5 Write DA=16'hFF00 DD=16'h1234 -> OUTP=16'h1234. Read DA=16'hFF01 -> 16'h0002.
//    Write DA=16'h0200 -> ERR=1, WCNT unchanged.
//  6 Assert RST at sweep count 40 -> BUSY stays 1 and the sweep restarts. Same-cycle LD_EN and
//    CPU write to A=5: mem[5]=LD_D and WCNT unchanged.

Source files
------------

// File: rtl/data_mem_unit_pkg.sv
// Purpose: shared constants, FSM/region encodings and status-word helper for data_mem_unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_mem_unit_pkg;

    localparam int          DMU_AW      = 7;
    localparam int          DMU_DEPTH   = 128;
    localparam logic [15:0] DMU_IO_BASE = 16'hFF00;
    localparam logic [15:0] OUT_OFS     = 16'h0000;
    localparam logic [15:0] STAT_OFS    = 16'h0001;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RG_RAM  = 2'd0,
        RG_OUT  = 2'd1,
        RG_STAT = 2'd2,
        RG_NONE = 2'd3
    } region_e;

    function automatic logic [15:0] status_word(input logic done, input logic busy);
        logic [15:0] w;
        w                = '0;
        w[STAT_DONE_BIT] = done;
        w[STAT_BUSY_BIT] = busy;
        return w;
    endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Purpose: CPU data-side address/direction and preload strobe bundle for data_mem_unit.
// Latency: n/a (wires only).
// Backpressure: none; the memory stage accepts every access presented while running.
// Ports: DA (address), RW (1 = read), LD_EN/LD_A/LD_D (preload). The bidirectional
// data bus DD stays a plain inout on the top so its tristate resolution is explicit.
interface data_mem_unit_if
    import data_mem_unit_pkg::*;
#(
    parameter int AW = DMU_AW
) ();

    logic [15:0]   DA;
    logic          RW;
    logic          LD_EN;
    logic [AW-1:0] LD_A;
    logic [15:0]   LD_D;

    modport master (output DA, RW, LD_EN, LD_A, LD_D);
    modport slave  (input  DA, RW, LD_EN, LD_A, LD_D);

endinterface

// File: rtl/dmem_ram.sv
// Purpose: 2**AW x DW synchronous RAM, one write port plus an independent registered read.
// Latency: write commits on the edge; read data appears 1 cycle after re (read-before-write on same edge).
// Backpressure: none.
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata, re/raddr, rdata.
module dmem_ram #(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;

    // Storage itself is never reset; the owner clears it with a sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// Purpose: CPU data-side memory stage: RAM, OUTP/status I/O window, DONE detector, post-reset clear sweep.
// Latency: writes commit on the edge; reads return on DD one cycle after the address is presented.
// Backpressure: none to the CPU; BUSY high during the clear sweep, where CPU and preload are ignored.
// Ports: CK, RST (async active-low), bus (DA/RW/LD_*), DD (inout data), BUSY, DONE, ERR, OUTP, WCNT.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int          DEPTH     = DMU_DEPTH,
    parameter int          AW        = DMU_AW,
    parameter logic [15:0] IO_BASE   = DMU_IO_BASE,
    parameter logic [15:0] DONE_ADDR = 16'h0000,
    parameter logic [15:0] DONE_VAL  = 16'h0004,
    parameter bit          INIT_CLR  = 1'b1
) (
    input  logic           CK,
    input  logic           RST,
    data_mem_unit_if.slave bus,
    inout  wire  [15:0]    DD,
    output logic           BUSY,
    output logic           DONE,
    output logic           ERR,
    output logic [15:0]    OUTP,
    output logic [15:0]    WCNT
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam state_e        RST_STATE = INIT_CLR ? ST_INIT : ST_RUN;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   outp_q, outp_d;
    logic [15:0]   wcnt_q, wcnt_d;
    logic [15:0]   io_rd_q, io_rd_d;
    logic          rd_ram_q, rd_ram_d;

    region_e       region;
    logic          wcnt_inc;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [15:0]   ram_wd;
    logic          ram_re;
    logic [15:0]   ram_rdata;
    logic [15:0]   rd_q;
    logic          dd_oe;

    always_comb begin
        if ({1'b0, bus.DA} < 17'(DEPTH)) begin
            region = RG_RAM;
        end else if (bus.DA == IO_BASE + OUT_OFS) begin
            region = RG_OUT;
        end else if (bus.DA == IO_BASE + STAT_OFS) begin
            region = RG_STAT;
        end else begin
            region = RG_NONE;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        err_d    = err_q;
        outp_d   = outp_q;
        wcnt_d   = wcnt_q;
        io_rd_d  = io_rd_q;
        rd_ram_d = rd_ram_q;
        wcnt_inc = 1'b0;
        ram_we   = 1'b0;
        ram_wa   = '0;
        ram_wd   = '0;
        ram_re   = 1'b0;

        case (state_q)
            ST_INIT: begin
                // One zero-write per cycle; bus and preload are not looked at.
                ram_we = 1'b1;
                ram_wa = cnt_q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Preload owns the write port; a same-cycle CPU RAM write is lost.
                if (bus.LD_EN) begin
                    ram_we = 1'b1;
                    ram_wa = AW'(bus.LD_A);
                    ram_wd = bus.LD_D;
                end
                if (!bus.RW) begin
                    case (region)
                        RG_RAM: begin
                            if (!bus.LD_EN) begin
                                ram_we   = 1'b1;
                                ram_wa   = bus.DA[AW-1:0];
                                ram_wd   = DD;
                                wcnt_inc = 1'b1;
                            end
                        end
                        RG_OUT: begin
                            outp_d   = DD;
                            wcnt_inc = 1'b1;
                        end
                        RG_STAT: ;
                        default: err_d = 1'b1;
                    endcase
                    // Completion marker is matched on the raw bus, independent of decode.
                    if (bus.DA == DONE_ADDR && DD == DONE_VAL) begin
                        done_d = 1'b1;
                    end
                end else begin
                    rd_ram_d = (region == RG_RAM);
                    case (region)
                        RG_RAM:  ram_re  = 1'b1;
                        RG_OUT:  io_rd_d = outp_q;
                        RG_STAT: io_rd_d = status_word(done_q, BUSY);
                        default: begin
                            io_rd_d = 16'h0000;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = RST_STATE;
        endcase

        if (wcnt_inc && wcnt_q != 16'hFFFF) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            outp_q   <= '0;
            wcnt_q   <= '0;
            io_rd_q  <= '0;
            rd_ram_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            outp_q   <= outp_d;
            wcnt_q   <= wcnt_d;
            io_rd_q  <= io_rd_d;
            rd_ram_q <= rd_ram_d;
        end
    end

    dmem_ram #(
        .AW (AW),
        .DW (16)
    ) u_ram (
        .clk   (CK),
        .rst_n (RST),
        .we    (ram_we),
        .waddr (ram_wa),
        .wdata (ram_wd),
        .re    (ram_re),
        .raddr (bus.DA[AW-1:0]),
        .rdata (ram_rdata)
    );

    // RAM data is already registered inside the RAM; I/O data is registered here.
    assign rd_q  = rd_ram_q ? ram_rdata : io_rd_q;
    assign dd_oe = bus.RW && (state_q == ST_RUN);
    assign DD    = dd_oe ? rd_q : {16{1'bz}};

    assign BUSY = (state_q == ST_INIT);
    assign DONE = done_q;
    assign ERR  = err_q;
    assign OUTP = outp_q;
    assign WCNT = wcnt_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Purpose: self-checking bench for data_mem_unit (sweep timing, reads/writes, I/O window, preload, reset).
// Latency: read expectations are queued on drive and popped one cycle later.
// Backpressure: none; BUSY waits are bounded.
module tb_data_mem_unit;
    import data_mem_unit_pkg::*;

    logic        CK = 1'b0;
    logic        RST;
    logic        tb_oe;
    logic [15:0] tb_dd;
    wire  [15:0] DD;
    logic        BUSY, DONE, ERR;
    logic [15:0] OUTP, WCNT;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_cyc;
    logic [15:0] exp_q[$];

    typedef struct {
        logic        rw;
        logic [15:0] da;
        logic [15:0] dd;
        logic [15:0] exp_rd;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_wcnt;
        logic [15:0] exp_outp;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    data_mem_unit_if #(.AW(7)) bus ();

    assign DD = tb_oe ? tb_dd : {16{1'bz}};

    always #5 CK = ~CK;

    data_mem_unit #(
        .DEPTH     (128),
        .AW        (7),
        .IO_BASE   (16'hFF00),
        .DONE_ADDR (16'h0000),
        .DONE_VAL  (16'h0004),
        .INIT_CLR  (1'b1)
    ) dut (
        .CK   (CK),
        .RST  (RST),
        .bus  (bus),
        .DD   (DD),
        .BUSY (BUSY),
        .DONE (DONE),
        .ERR  (ERR),
        .OUTP (OUTP),
        .WCNT (WCNT)
    );

    function automatic vec_t mk(input logic rw, input logic [15:0] da, input logic [15:0] dd,
                                input logic [15:0] erd, input logic edone, input logic eerr,
                                input logic [15:0] ewcnt, input logic [15:0] eoutp);
        vec_t v;
        v.rw = rw; v.da = da; v.dd = dd; v.exp_rd = erd;
        v.exp_done = edone; v.exp_err = eerr; v.exp_wcnt = ewcnt; v.exp_outp = eoutp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        tb_oe      = 1'b0;
        bus.RW     = 1'b1;
        bus.DA     = 16'h0000;
        bus.LD_EN  = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.RW = 1'b0;
        bus.DA = a;
        tb_dd  = d;
        tb_oe  = 1'b1;
        @(negedge CK);
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [15:0] e);
        logic [15:0] exp;
        tb_oe  = 1'b0;
        bus.RW = 1'b1;
        bus.DA = a;
        exp_q.push_back(e);
        @(negedge CK);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, DD);
        end else begin
            exp = exp_q.pop_front();
            chk(name, DD, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1'b0, 16'h0003, 16'h00AA, 16'h0000, 1'b0, 1'b0, 16'd1, 16'h0000);
        vecs[1]  = mk(1'b1, 16'h0003, 16'h0000, 16'h00AA, 1'b0, 1'b0, 16'd1, 16'h0000);
        vecs[2]  = mk(1'b0, 16'h0000, 16'h0004, 16'h0000, 1'b1, 1'b0, 16'd2, 16'h0000);
        vecs[3]  = mk(1'b0, 16'h0000, 16'h0007, 16'h0000, 1'b1, 1'b0, 16'd3, 16'h0000);
        vecs[4]  = mk(1'b1, 16'h0000, 16'h0000, 16'h0007, 1'b1, 1'b0, 16'd3, 16'h0000);
        vecs[5]  = mk(1'b0, 16'hFF00, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'd4, 16'h1234);
        vecs[6]  = mk(1'b1, 16'hFF00, 16'h0000, 16'h1234, 1'b1, 1'b0, 16'd4, 16'h1234);
        vecs[7]  = mk(1'b1, 16'hFF01, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'd4, 16'h1234);
        vecs[8]  = mk(1'b0, 16'hFF01, 16'h5555, 16'h0000, 1'b1, 1'b0, 16'd4, 16'h1234);
        vecs[9]  = mk(1'b0, 16'h007F, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 16'd5, 16'h1234);
        vecs[10] = mk(1'b1, 16'h007F, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'd5, 16'h1234);
        vecs[11] = mk(1'b1, 16'h0001, 16'h0000, 16'd50,   1'b1, 1'b0, 16'd5, 16'h1234);
        vecs[12] = mk(1'b0, 16'h0200, 16'h9999, 16'h0000, 1'b1, 1'b1, 16'd5, 16'h1234);
        vecs[13] = mk(1'b1, 16'h0080, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'd5, 16'h1234);
        vecs[14] = mk(1'b1, 16'h0003, 16'h0000, 16'h00AA, 1'b1, 1'b1, 16'd5, 16'h1234);

        // Reset state.
        RST       = 1'b1;
        tb_dd     = 16'h0000;
        bus.LD_A  = '0;
        bus.LD_D  = 16'h0000;
        idle();
        #2 RST = 1'b0;
        #1;
        chk("rst_busy", {15'b0, BUSY}, 16'd1);
        chk("rst_done", {15'b0, DONE}, 16'd0);
        chk("rst_err",  {15'b0, ERR},  16'd0);
        chk("rst_outp", OUTP, 16'h0000);
        chk("rst_wcnt", WCNT, 16'h0000);
        repeat (3) @(negedge CK);
        RST = 1'b1;

        // Sweep length: BUSY high for exactly 128 edges after release.
        n_cyc = 0;
        while (BUSY && n_cyc < 400) begin
            @(posedge CK);
            #1;
            n_cyc++;
        end
        chk("sweep_len", 16'(n_cyc), 16'd128);
        @(negedge CK);
        for (int a = 0; a < 128; a++) begin
            rd($sformatf("clr_rd_%0d", a), 16'(a), 16'h0000);
        end

        // Preload, then read back in reverse order.
        bus.LD_EN = 1'b1; bus.LD_A = 7'd0; bus.LD_D = 16'd5;
        @(negedge CK);
        bus.LD_A = 7'd1; bus.LD_D = 16'd50;
        @(negedge CK);
        bus.LD_EN = 1'b0;
        chk("pre_wcnt", WCNT, 16'h0000);
        rd("pre_rd1", 16'h0001, 16'd50);
        rd("pre_rd0", 16'h0000, 16'd5);

        // Table: writes, read-after-write, DONE, I/O window, unmapped.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rw) begin
                rd($sformatf("v%0d_rd", i), vecs[i].da, vecs[i].exp_rd);
            end else begin
                wr(vecs[i].da, vecs[i].dd);
            end
            chk($sformatf("v%0d_done", i), {15'b0, DONE}, {15'b0, vecs[i].exp_done});
            chk($sformatf("v%0d_err", i),  {15'b0, ERR},  {15'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_wcnt", i), WCNT, vecs[i].exp_wcnt);
            chk($sformatf("v%0d_outp", i), OUTP, vecs[i].exp_outp);
        end
        idle();

        // Reset at sweep count 40: state cleared, sweep restarts from 0.
        RST = 1'b0;
        @(negedge CK);
        RST = 1'b1;
        repeat (40) @(posedge CK);
        @(negedge CK);
        chk("mid_busy", {15'b0, BUSY}, 16'd1);
        RST = 1'b0;
        #1;
        chk("mid_rst_busy", {15'b0, BUSY}, 16'd1);
        @(negedge CK);
        RST = 1'b1;
        n_cyc = 0;
        while (BUSY && n_cyc < 400) begin
            @(posedge CK);
            #1;
            n_cyc++;
            // CPU write and preload during the sweep must both be ignored.
            if (n_cyc == 50) begin
                bus.LD_EN = 1'b1; bus.LD_A = 7'd3; bus.LD_D = 16'hABCD;
                bus.RW = 1'b0; bus.DA = 16'hFF00; tb_dd = 16'hFFFF; tb_oe = 1'b1;
            end else if (n_cyc == 51) begin
                idle();
            end
        end
        chk("resweep_len", 16'(n_cyc), 16'd128);
        @(negedge CK);
        chk("resweep_outp", OUTP, 16'h0000);
        chk("resweep_wcnt", WCNT, 16'h0000);
        chk("resweep_done", {15'b0, DONE}, 16'd0);
        chk("resweep_err",  {15'b0, ERR},  16'd0);
        rd("resweep_rd7f", 16'h007F, 16'h0000);
        rd("resweep_rd3",  16'h0003, 16'h0000);

        // Preload beats a same-cycle CPU RAM write, same and different address.
        bus.LD_EN = 1'b1; bus.LD_A = 7'd5; bus.LD_D = 16'h1111;
        wr(16'h0005, 16'h2222);
        bus.LD_A = 7'd6; bus.LD_D = 16'h6666;
        wr(16'h0009, 16'h9999);
        bus.LD_EN = 1'b0;
        chk("ldpri_wcnt", WCNT, 16'h0000);
        rd("ldpri_rd5", 16'h0005, 16'h1111);
        rd("ldpri_rd6", 16'h0006, 16'h6666);
        rd("ldpri_rd9", 16'h0009, 16'h0000);
        wr(16'h0004, 16'h4444);
        chk("post_wcnt", WCNT, 16'h0001);
        rd("post_rd4", 16'h0004, 16'h4444);

        // Unmapped read returns zero and sets ERR.
        chk("pre_uerr", {15'b0, ERR}, 16'd0);
        rd("unmap_rd", 16'h1234, 16'h0000);
        chk("unmap_err", {15'b0, ERR}, 16'd1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
